led_frame_serializer: RTL and testbench

Upstream feeder for the LED matrix driver: accepts a complete 64-LED frame as a parallel word over a valid/ready handshake and replays it on the driver's three-wire serial port (`din`, `dclk`, `strobe`). Bits are ordered so that `frame_data[j]` lands in driver display-buffer bit `j`. After the last bit, one `strobe` pulse latches the frame. The block runs in the system clock domain. It generates `dclk` and `strobe` as registered, slowed-down levels, so the driver sees clean edges.

---
 rtl/led_matrix_pkg.sv | 15 +
 rtl/led_frame_serializer_if.sv | 13 +
 rtl/led_ser_tick.sv | 30 +++
 rtl/led_frame_serializer.sv | 167 ++++++++++++++++
 tb/tb_led_frame_serializer.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/led_matrix_pkg.sv
// Shared defaults and FSM state type for the LED frame serializer.
package led_matrix_pkg;

  localparam int unsigned NLEDS_DEFAULT = 64;
  localparam int unsigned DIV_DEFAULT   = 2;

  typedef enum logic [2:0] {
    StIdle,
    StShiftLo,
    StShiftHi,
    StStbLo,
    StStbHi
  } ser_state_t;

endpackage

// File: rtl/led_frame_serializer_if.sv
// Frame handshake between a frame source (master) and the serializer (slave).
interface led_frame_serializer_if #(
  parameter int unsigned NLEDS = 64
) ();

  logic [NLEDS-1:0] frame_data;
  logic             frame_valid;
  logic             frame_ready;

  modport master (output frame_data, output frame_valid, input frame_ready);
  modport slave  (input frame_data, input frame_valid, output frame_ready);

endinterface

// File: rtl/led_ser_tick.sv
// Half-period timer: one-cycle o_tick every DIV cycles while enabled, cleared when disabled.
module led_ser_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_en,
  output logic o_tick
);

  localparam int unsigned CntW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CntW-1:0] Last = CntW'(DIV - 1);

  logic [CntW-1:0] r_cnt;
  logic            w_wrap;

  assign w_wrap = (r_cnt == Last);
  assign o_tick = i_en & w_wrap;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!i_en || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CntW'(1);
    end
  end

endmodule

// File: rtl/led_frame_serializer.sv
// Replays a parallel NLEDS-bit frame on the driver's din/dclk/strobe port, MSB first.
// Define LED_SER_DOUBLE_BUFFER_EN to accept the next frame while the current one shifts out.
module led_frame_serializer
  import led_matrix_pkg::*;
#(
  parameter int unsigned NLEDS = NLEDS_DEFAULT,
  parameter int unsigned DIV   = DIV_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  led_frame_serializer_if.slave s_frame,
  output logic                  o_din,
  output logic                  o_dclk,
  output logic                  o_strobe,
  output logic                  o_busy,
  output logic                  o_frame_done
);

  localparam int unsigned CntW = $clog2(NLEDS + 1);

  ser_state_t       r_state;
  ser_state_t       w_state_next;
  logic [NLEDS-1:0] r_shift;
  logic [CntW-1:0]  r_bitcnt;
  logic             r_out_en;
  logic             r_din;
  logic             r_dclk;
  logic             r_strobe;
  logic             r_frame_done;
  logic             w_tick;
  logic             w_accept;
  logic             w_last_bit;
  logic             w_load_new;
  logic             w_shift_step;
  logic             w_done;

  assign w_accept   = s_frame.frame_valid & s_frame.frame_ready;
  assign w_last_bit = (r_bitcnt == CntW'(NLEDS - 1));

  led_ser_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk   (clk),
    .reset (reset),
    .i_en  (r_state != StIdle),
    .o_tick(w_tick)
  );

`ifdef LED_SER_DOUBLE_BUFFER_EN
  logic [NLEDS-1:0] r_hold;
  logic             r_held;
  logic             w_load_held;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold <= '0;
      r_held <= 1'b0;
    end else if (w_accept && !w_load_new) begin
      r_hold <= s_frame.frame_data;
      r_held <= 1'b1;
    end else if (w_load_held) begin
      r_held <= 1'b0;
    end
  end

  assign s_frame.frame_ready = r_out_en & ~r_held;
`else
  assign s_frame.frame_ready = r_out_en & (r_state == StIdle);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= StIdle;
      r_out_en <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_out_en <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load_new   = 1'b0;
    w_shift_step = 1'b0;
    w_done       = 1'b0;
`ifdef LED_SER_DOUBLE_BUFFER_EN
    w_load_held  = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_load_new   = 1'b1;
          w_state_next = StShiftLo;
        end
      end
      StShiftLo: begin
        if (w_tick) w_state_next = StShiftHi;
      end
      StShiftHi: begin
        if (w_tick) begin
          w_shift_step = 1'b1;
          w_state_next = w_last_bit ? StStbLo : StShiftLo;
        end
      end
      StStbLo: begin
        if (w_tick) w_state_next = StStbHi;
      end
      StStbHi: begin
        if (w_tick) begin
          w_done       = 1'b1;
          w_state_next = StIdle;
`ifdef LED_SER_DOUBLE_BUFFER_EN
          // Chain straight into the next frame so the driver sees no idle gap.
          if (r_held) begin
            w_load_held  = 1'b1;
            w_state_next = StShiftLo;
          end else if (w_accept) begin
            w_load_new   = 1'b1;
            w_state_next = StShiftLo;
          end
`endif
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
    end else if (w_load_new) begin
      r_shift  <= s_frame.frame_data;
      r_bitcnt <= '0;
`ifdef LED_SER_DOUBLE_BUFFER_EN
    end else if (w_load_held) begin
      r_shift  <= r_hold;
      r_bitcnt <= '0;
`endif
    end else if (w_shift_step) begin
      r_shift  <= {r_shift[NLEDS-2:0], 1'b0};
      r_bitcnt <= r_bitcnt + CntW'(1);
    end
  end

  // Outputs follow the current state one cycle later, so din only moves as dclk falls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din        <= 1'b0;
      r_dclk       <= 1'b0;
      r_strobe     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_din        <= ((r_state == StShiftLo) || (r_state == StShiftHi)) & r_shift[NLEDS-1];
      r_dclk       <= (r_state == StShiftHi);
      r_strobe     <= (r_state == StStbHi);
      r_frame_done <= w_done;
    end
  end

  assign o_din        = r_din;
  assign o_dclk       = r_dclk;
  assign o_strobe     = r_strobe;
  assign o_frame_done = r_frame_done;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_led_frame_serializer.sv
// Two serializers (DIV=2 and DIV=1) against a shift-register driver model and frame-timing arithmetic.
module tb_led_frame_serializer;
  import led_matrix_pkg::*;

  localparam int unsigned N    = NLEDS_DEFAULT;
  localparam int unsigned DivA = 2;
  localparam int unsigned DivB = 1;
`ifdef LED_SER_DOUBLE_BUFFER_EN
  localparam int Spacing = 2 * DivA * (N + 1);
`else
  localparam int Spacing = 2 * DivA * (N + 1) + 1;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_frame_serializer_if #(.NLEDS(N)) if_a ();
  led_frame_serializer_if #(.NLEDS(N)) if_b ();
  logic din_a, dclk_a, stb_a, busy_a, done_a;
  logic din_b, dclk_b, stb_b, busy_b, done_b;

  led_frame_serializer #(.NLEDS(N), .DIV(DivA)) u_dut_a (
    .clk(clk), .reset(reset), .s_frame(if_a), .o_din(din_a), .o_dclk(dclk_a),
    .o_strobe(stb_a), .o_busy(busy_a), .o_frame_done(done_a)
  );
  led_frame_serializer #(.NLEDS(N), .DIV(DivB)) u_dut_b (
    .clk(clk), .reset(reset), .s_frame(if_b), .o_din(din_b), .o_dclk(dclk_b),
    .o_strobe(stb_b), .o_busy(busy_b), .o_frame_done(done_b)
  );

  // Driver model: shift din in at each dclk rise, latch the buffer at each strobe rise.
  logic m_din[2], m_dclk[2], m_stb[2], m_hs[2], m_done[2];
  assign m_din[0] = din_a;   assign m_din[1] = din_b;
  assign m_dclk[0] = dclk_a; assign m_dclk[1] = dclk_b;
  assign m_stb[0] = stb_a;   assign m_stb[1] = stb_b;
  assign m_done[0] = done_a; assign m_done[1] = done_b;
  assign m_hs[0] = if_a.frame_valid & if_a.frame_ready;
  assign m_hs[1] = if_b.frame_valid & if_b.frame_ready;

  logic [N-1:0] vbuf[2];
  logic prev_din[2], prev_dclk[2], prev_stb[2];
  int stable[2], rises[2], rises_since[2], first_rise_cyc[2];
  int strobes[2], bad_strobe[2], setup_viol[2], hs[2], dones[2];
  logic [N-1:0] lat_q0[$], lat_q1[$];
  int stb_cyc0[$];

  function automatic int div_of(input int i);
    return (i == 0) ? int'(DivA) : int'(DivB);
  endfunction

  initial begin
    for (int i = 0; i < 2; i++) begin
      vbuf[i] = '0; stable[i] = 0; rises[i] = 0; rises_since[i] = 0; first_rise_cyc[i] = 0;
      strobes[i] = 0; bad_strobe[i] = 0; setup_viol[i] = 0; hs[i] = 0; dones[i] = 0;
      prev_din[i] = 1'b0; prev_dclk[i] = 1'b0; prev_stb[i] = 1'b0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        rises_since[i] <= 0;
        stable[i]      <= 0;
      end else begin
        stable[i] <= (m_din[i] !== prev_din[i]) ? 0 : stable[i] + 1;
        if (m_dclk[i] && !prev_dclk[i]) begin
          rises[i]       <= rises[i] + 1;
          rises_since[i] <= rises_since[i] + 1;
          if (rises_since[i] == 0) first_rise_cyc[i] <= cyc;
          if (m_din[i] !== prev_din[i] || stable[i] + 1 < div_of(i))
            setup_viol[i] <= setup_viol[i] + 1;
          vbuf[i] <= {vbuf[i][N-2:0], m_din[i]};
        end
        if (m_stb[i] && !prev_stb[i]) begin
          strobes[i]     <= strobes[i] + 1;
          rises_since[i] <= 0;
          if (rises_since[i] != int'(N)) bad_strobe[i] <= bad_strobe[i] + 1;
          if (i == 0) begin
            lat_q0.push_back(vbuf[0]);
            stb_cyc0.push_back(cyc);
          end else begin
            lat_q1.push_back(vbuf[1]);
          end
        end
        if (m_hs[i]) hs[i] <= hs[i] + 1;
        if (m_done[i]) dones[i] <= dones[i] + 1;
      end
      prev_din[i]  <= m_din[i];
      prev_dclk[i] <= m_dclk[i];
      prev_stb[i]  <= m_stb[i];
    end
  end

  task automatic set_in(input int idx, input logic v, input logic [N-1:0] d);
    if (idx == 0) begin if_a.frame_valid = v; if_a.frame_data = d; end
    else begin if_b.frame_valid = v; if_b.frame_data = d; end
  endtask

  function automatic logic get_ready(input int idx);
    return (idx == 0) ? if_a.frame_ready : if_b.frame_ready;
  endfunction

  // {din, dclk, strobe, busy, frame_done}
  function automatic logic [4:0] outs(input int idx);
    return (idx == 0) ? {din_a, dclk_a, stb_a, busy_a, done_a} : {din_b, dclk_b, stb_b, busy_b, done_b};
  endfunction

  // Called at posedge+1; returns the cycle of the accepting edge, or -1.
  task automatic send(input int idx, input logic [N-1:0] d, output int acc);
    int n = 0;
    acc = -1;
    set_in(idx, 1'b1, d);
    while (acc < 0 && n < 2000) begin
      if (get_ready(idx)) begin @(posedge clk); #1; acc = cyc; end
      else begin @(posedge clk); #1; n++; end
    end
    set_in(idx, 1'b0, '0);
  endtask

  task automatic wait_done(input int idx, output int dcyc);
    dcyc = -1;
    for (int n = 0; n < 5000 && dcyc < 0; n++) begin
      @(posedge clk); #1;
      if (outs(idx)[0]) dcyc = cyc;
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    reset = 1'b1;
    set_in(0, 1'b0, '0); set_in(1, 1'b0, '0);
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({get_ready(0), get_ready(1), outs(0), outs(1)} !== 12'd0) begin
      failures++; $display("FAIL reset_hold: got %b expected 0", {get_ready(0), get_ready(1), outs(0), outs(1)});
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({get_ready(0), get_ready(1)} !== 2'b11) begin
      failures++; $display("FAIL reset_ready: got %b expected 11", {get_ready(0), get_ready(1)});
    end
    for (int n = 0; n < 40; n++) begin
      if (outs(0) !== 5'd0 || outs(1) !== 5'd0 || !get_ready(0) || !get_ready(1)) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL idle_quiet: got %0d bad cycles expected 0", bad); end
  endtask

  task automatic run_frame(input int idx, input logic [N-1:0] d, input string nm);
    int acc, dcyc, s0, r0, q0, exp_dur;
    logic [N-1:0] got;
    s0 = strobes[idx]; r0 = rises[idx];
    q0 = (idx == 0) ? lat_q0.size() : lat_q1.size();
    exp_dur = 2 * div_of(idx) * (int'(N) + 1);
    send(idx, d, acc);
    wait_done(idx, dcyc);
    checks++;
    if (acc < 0 || dcyc < 0 || dcyc - acc != exp_dur) begin
      failures++; $display("FAIL %s_duration: got %0d expected %0d", nm, dcyc - acc, exp_dur);
    end
    checks++;
    if (first_rise_cyc[idx] - acc != div_of(idx) + 1) begin
      failures++; $display("FAIL %s_first_rise: got %0d expected %0d", nm, first_rise_cyc[idx] - acc, div_of(idx) + 1);
    end
    checks++;
    if ({outs(idx)[1], get_ready(idx)} !== 2'b01) begin
      failures++; $display("FAIL %s_idle_after: got busy,ready=%b expected 01", nm, {outs(idx)[1], get_ready(idx)});
    end
    @(posedge clk); #1;
    checks++;
    if (rises[idx] - r0 != int'(N) || strobes[idx] - s0 != 1) begin
      failures++; $display("FAIL %s_edges: got rises=%0d strobes=%0d expected %0d 1", nm, rises[idx] - r0, strobes[idx] - s0, N);
    end
    got = '0;
    if (idx == 0 && lat_q0.size() > q0) got = lat_q0[q0];
    if (idx == 1 && lat_q1.size() > q0) got = lat_q1[q0];
    checks++;
    if (got !== d) begin failures++; $display("FAIL %s_vbuf: got %h expected %h", nm, got, d); end
  endtask

  task automatic test_single_frame();
    run_frame(0, 64'h8000_0000_0000_0001, "corner");
    run_frame(0, {$urandom, $urandom}, "rand_a0");
    run_frame(0, {$urandom, $urandom}, "rand_a1");
  endtask

  task automatic test_div1();
    run_frame(1, 64'hAAAA_AAAA_AAAA_AAAA, "div1_alt");
    run_frame(1, {$urandom, $urandom}, "div1_rand");
  endtask

  task automatic test_integrity();
    checks++;
    if (setup_viol[0] != 0 || setup_viol[1] != 0) begin
      failures++; $display("FAIL din_setup: got %0d/%0d violations expected 0", setup_viol[0], setup_viol[1]);
    end
    checks++;
    if (bad_strobe[0] != 0 || bad_strobe[1] != 0) begin
      failures++; $display("FAIL strobe_rises: got %0d/%0d bad strobes expected 0", bad_strobe[0], bad_strobe[1]);
    end
  endtask

  task automatic test_reset_mid_frame();
    int acc, s0, r0;
    s0 = strobes[0]; r0 = rises[0];
    send(0, {$urandom, $urandom}, acc);
    for (int n = 0; n < 2000 && rises[0] - r0 < 20; n++) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    checks++;
    if ({get_ready(0), outs(0)} !== 6'd0) begin
      failures++; $display("FAIL midreset_outs: got %b expected 0", {get_ready(0), outs(0)});
    end
    repeat (3) @(posedge clk); #1;
    reset = 1'b0;
    repeat (300) @(posedge clk); #1;
    checks++;
    if (strobes[0] != s0 || rises[0] - r0 != 20) begin
      failures++; $display("FAIL midreset_nostrobe: got strobes=%0d rises=%0d expected %0d 20", strobes[0], rises[0] - r0, s0);
    end
    run_frame(0, 64'hFF, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] f[3];
    int k = 0, n = 0, s0, q0, h0, d0;
    for (int i = 0; i < 3; i++) f[i] = {$urandom, $urandom};
    s0 = strobes[0]; q0 = lat_q0.size(); h0 = hs[0]; d0 = dones[0];
    set_in(0, 1'b1, f[0]);
    while (k < 3 && n < 3000) begin
      if (get_ready(0)) begin
        @(posedge clk); #1; k++;
        if (k < 3) set_in(0, 1'b1, f[k]); else set_in(0, 1'b0, '0);
      end else begin
        @(posedge clk); #1;
      end
      n++;
    end
    for (int m = 0; m < 3000 && dones[0] - d0 < 3; m++) begin @(posedge clk); #1; end
    checks++;
    if (k != 3 || hs[0] - h0 != 3 || dones[0] - d0 != 3) begin
      failures++; $display("FAIL b2b_count: got acc=%0d hs=%0d done=%0d expected 3", k, hs[0] - h0, dones[0] - d0);
    end
    if (strobes[0] - s0 == 3) begin
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (stb_cyc0[q0 + i + 1] - stb_cyc0[q0 + i] != Spacing) begin
          failures++; $display("FAIL b2b_spacing%0d: got %0d expected %0d", i, stb_cyc0[q0 + i + 1] - stb_cyc0[q0 + i], Spacing);
        end
      end
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (lat_q0[q0 + i] !== f[i]) begin
          failures++; $display("FAIL b2b_vbuf%0d: got %h expected %h", i, lat_q0[q0 + i], f[i]);
        end
      end
    end else begin
      checks++; failures++;
      $display("FAIL b2b_strobes: got %0d expected 3", strobes[0] - s0);
    end
  endtask

  task automatic test_valid_drop();
    logic [N-1:0] fx, fy;
    int acc, c = 0, s0, q0, h0, d0;
    bit got = 0, will;
    logic v;
    fx = {$urandom, $urandom}; fy = {$urandom, $urandom};
    s0 = strobes[0]; q0 = lat_q0.size(); h0 = hs[0]; d0 = dones[0];
    send(0, fx, acc);
    repeat (10) @(posedge clk); #1;
    while (!got && c < 1000) begin
      v = (c != 5);
      set_in(0, v, fy);
      will = v && get_ready(0);
      @(posedge clk); #1;
      if (will) got = 1;
      c++;
    end
    set_in(0, 1'b0, '0);
    for (int m = 0; m < 3000 && dones[0] - d0 < 2; m++) begin @(posedge clk); #1; end
    repeat (20) @(posedge clk); #1;
    checks++;
    if (!got || hs[0] - h0 != 2 || strobes[0] - s0 != 2 || dones[0] - d0 != 2) begin
      failures++;
      $display("FAIL drop_counts: got hs=%0d strobes=%0d done=%0d expected 2 2 2", hs[0] - h0, strobes[0] - s0, dones[0] - d0);
    end
    checks++;
    if (lat_q0.size() != q0 + 2 || lat_q0[q0] !== fx || lat_q0[q0 + 1] !== fy) begin
      failures++; $display("FAIL drop_order: got %0d frames expected 2 in order %h %h", lat_q0.size() - q0, fx, fy);
    end
  endtask

  initial begin
    set_in(0, 1'b0, '0);
    set_in(1, 1'b0, '0);
    test_reset();
    test_single_frame();
    test_div1();
    test_reset_mid_frame();
    test_back_to_back();
    test_valid_drop();
    test_integrity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
